// File: rtl/direction_ctrl_module.sv
// -----------------------------------------------------------------------------
// direction_ctrl_module
//
// Heading controller for a grid game. Single-key presses are filtered against
// the most recent requested heading (or the current heading when nothing is
// queued) and, when legal, are stored in a 2-entry FIFO. Each game-step strobe
// pops one queued heading into the registered output heading and raises a
// one-cycle turn pulse. Pausing the game flushes the queue and freezes the
// heading. Every rejected key event bumps a saturating counter.
//
// Ports
//   clk_50mhz_i   in   1  system clock, all state on rising edge
//   rst_i         in   1  synchronous reset, active-high, highest priority
//   key_left_i    in   1  key-press pulse, left
//   key_right_i   in   1  key-press pulse, right
//   key_up_i      in   1  key-press pulse, up
//   key_down_i    in   1  key-press pulse, down
//   move_tick_i   in   1  single-cycle game-step strobe
//   game_en_i     in   1  level, 1 = play, 0 = paused / flushed
//   dir_o         out  2  current heading: 00 up, 01 down, 10 left, 11 right
//   turn_o        out  1  high for the one cycle a newly popped heading appears
//   q_count_o     out  2  number of queued headings, 0..2
//   rej_cnt_o     out  8  rejected key events, saturating at 255
// -----------------------------------------------------------------------------
module direction_ctrl_module (
    input  logic       clk_50mhz_i,
    input  logic       rst_i,
    input  logic       key_left_i,
    input  logic       key_right_i,
    input  logic       key_up_i,
    input  logic       key_down_i,
    input  logic       move_tick_i,
    input  logic       game_en_i,
    output logic [1:0] dir_o,
    output logic       turn_o,
    output logic [1:0] q_count_o,
    output logic [7:0] rej_cnt_o
);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // State registers
    logic [1:0] dir_q,     dir_d;
    logic       turn_q,    turn_d;
    logic [1:0] count_q,   count_d;
    logic       head_q,    head_d;
    logic       tail_q,    tail_d;
    logic [7:0] rej_cnt_q, rej_cnt_d;
    logic [1:0] fifo_q [2];

    // Decode of the key inputs
    logic [2:0] n_keys;
    logic       key_event;
    logic       single_key;
    logic [1:0] req_dir;
    logic [1:0] ref_dir;
    logic       same_dir;
    logic       opp_dir;
    logic       pop;
    logic       push;
    logic       reject;

    always_comb begin
        n_keys = {2'b00, key_up_i} + {2'b00, key_down_i}
               + {2'b00, key_left_i} + {2'b00, key_right_i};
        key_event  = (n_keys != 3'd0);
        single_key = (n_keys == 3'd1);

        req_dir = DIR_UP;
        if (key_down_i)  req_dir = DIR_DOWN;
        if (key_left_i)  req_dir = DIR_LEFT;
        if (key_right_i) req_dir = DIR_RIGHT;

        // The tail entry is the slot just behind the write pointer; with two
        // slots that is simply the other slot.
        ref_dir = (count_q != 2'd0) ? fifo_q[~tail_q] : dir_q;

        same_dir = (req_dir == ref_dir);
        // Opposite pairs (up/down, left/right) differ only in bit 0.
        opp_dir  = (req_dir == {ref_dir[1], ~ref_dir[0]});

        pop    = game_en_i && move_tick_i && (count_q != 2'd0);
        // A full queue can still accept a push when a pop frees a slot at the
        // same edge.
        push   = game_en_i && single_key && !same_dir && !opp_dir
                 && ((count_q != 2'd2) || pop);
        reject = game_en_i && key_event && !push;
    end

    // Next-state logic
    always_comb begin
        dir_d     = dir_q;
        turn_d    = pop;
        count_d   = count_q;
        head_d    = head_q;
        tail_d    = tail_q;
        rej_cnt_d = rej_cnt_q;

        if (!game_en_i) begin
            // Paused: flush the queue, freeze the heading and counters.
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            if (pop) begin
                dir_d  = fifo_q[head_q];
                head_d = ~head_q;
            end
            if (push) begin
                tail_d = ~tail_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
            if (reject && (rej_cnt_q != 8'hFF)) begin
                rej_cnt_d = rej_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_50mhz_i) begin
        if (rst_i) begin
            dir_q     <= DIR_RIGHT;
            turn_q    <= 1'b0;
            count_q   <= 2'd0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            rej_cnt_q <= 8'd0;
        end else begin
            dir_q     <= dir_d;
            turn_q    <= turn_d;
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            rej_cnt_q <= rej_cnt_d;
        end
    end

    // Queue storage; contents are don't-care whenever count is zero, so the
    // data slots need no reset.
    always_ff @(posedge clk_50mhz_i) begin
        if (!rst_i && push) begin
            fifo_q[tail_q] <= req_dir;
        end
    end

    assign dir_o     = dir_q;
    assign turn_o    = turn_q;
    assign q_count_o = count_q;
    assign rej_cnt_o = rej_cnt_q;

endmodule

// File: tb/tb_direction_ctrl_module.sv
// -----------------------------------------------------------------------------
// tb_direction_ctrl_module
//
// Table of directed vectors for the basic scenarios, hand-written sequences for
// the long-hold / pause / reset corners, then randomized stimulus compared
// against a queue-based behavioural model.
// -----------------------------------------------------------------------------
module tb_direction_ctrl_module;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_left, key_right, key_up, key_down;
    logic       move_tick;
    logic       game_en;
    logic [1:0] dir;
    logic       turn;
    logic [1:0] q_count;
    logic [7:0] rej_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    direction_ctrl_module dut (
        .clk_50mhz_i (clk),
        .rst_i       (rst),
        .key_left_i  (key_left),
        .key_right_i (key_right),
        .key_up_i    (key_up),
        .key_down_i  (key_down),
        .move_tick_i (move_tick),
        .game_en_i   (game_en),
        .dir_o       (dir),
        .turn_o      (turn),
        .q_count_o   (q_count),
        .rej_cnt_o   (rej_cnt)
    );

    // Key vector bit order: {up, down, left, right}
    localparam logic [3:0] K_NONE  = 4'b0000;
    localparam logic [3:0] K_UP    = 4'b1000;
    localparam logic [3:0] K_DOWN  = 4'b0100;
    localparam logic [3:0] K_LEFT  = 4'b0010;
    localparam logic [3:0] K_RIGHT = 4'b0001;

    // ---------------- behavioural model ----------------
    // Headings as integers: 0 up, 1 down, 2 left, 3 right.
    int m_q[$];
    int m_dir;
    int m_turn;
    int m_rej;
    int opposite [4] = '{1, 0, 3, 2};

    function automatic int key_to_dir(input logic [3:0] k);
        if (k[3]) return 0;
        if (k[2]) return 1;
        if (k[1]) return 2;
        return 3;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] k,
                              input logic t, input logic e);
        int  ref_d;
        int  req;
        int  nk;
        bit  popping;
        bit  accept;
        if (r) begin
            m_q.delete();
            m_dir  = 3;
            m_turn = 0;
            m_rej  = 0;
        end else if (!e) begin
            m_q.delete();
            m_turn = 0;
        end else begin
            ref_d   = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
            popping = t && (m_q.size() > 0);
            nk      = $countones(k);
            req     = key_to_dir(k);
            accept  = (nk == 1) && (req != ref_d) && (req != opposite[ref_d])
                      && ((m_q.size() < 2) || popping);
            if (popping) m_dir = m_q.pop_front();
            m_turn = popping ? 1 : 0;
            if (accept) m_q.push_back(req);
            else if (nk > 0 && m_rej < 255) m_rej = m_rej + 1;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic step(input logic r, input logic [3:0] k,
                        input logic t, input logic e);
        rst       = r;
        {key_up, key_down, key_left, key_right} = k;
        move_tick = t;
        game_en   = e;
        @(posedge clk);
        #1;
        model_step(r, k, t, e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int e_dir, input int e_turn,
                             input int e_q, input int e_rej);
        check({tag, ".dir"},     int'(dir),     e_dir);
        check({tag, ".turn"},    int'(turn),    e_turn);
        check({tag, ".q_count"}, int'(q_count), e_q);
        check({tag, ".rej_cnt"}, int'(rej_cnt), e_rej);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       r;
        logic [3:0] k;
        logic       t;
        logic       e;
        int         e_dir;
        int         e_turn;
        int         e_q;
        int         e_rej;
    } vec_t;

    localparam int NTBL = 23;
    vec_t tbl [NTBL];

    function automatic vec_t mk(input logic r, input logic [3:0] k, input logic t,
                                input logic e, input int d, input int tu,
                                input int q, input int rj);
        vec_t v;
        v.r = r; v.k = k; v.t = t; v.e = e;
        v.e_dir = d; v.e_turn = tu; v.e_q = q; v.e_rej = rj;
        return v;
    endfunction

    initial begin
        // Reset and basic up-then-tick flow
        tbl[0]  = mk(1, K_NONE,  0, 1, 3, 0, 0, 0);
        tbl[1]  = mk(0, K_NONE,  0, 1, 3, 0, 0, 0);
        tbl[2]  = mk(0, K_UP,    0, 1, 3, 0, 1, 0);
        tbl[3]  = mk(0, K_NONE,  1, 1, 0, 1, 0, 0);
        tbl[4]  = mk(0, K_NONE,  0, 1, 0, 0, 0, 0);
        // Opposite then same-direction rejection from heading right
        tbl[5]  = mk(1, K_NONE,  0, 1, 3, 0, 0, 0);
        tbl[6]  = mk(0, K_LEFT,  0, 1, 3, 0, 0, 1);
        tbl[7]  = mk(0, K_RIGHT, 0, 1, 3, 0, 0, 2);
        // Fill queue, reject on full, drain with two ticks
        tbl[8]  = mk(1, K_NONE,  0, 1, 3, 0, 0, 0);
        tbl[9]  = mk(0, K_UP,    0, 1, 3, 0, 1, 0);
        tbl[10] = mk(0, K_LEFT,  0, 1, 3, 0, 2, 0);
        tbl[11] = mk(0, K_DOWN,  0, 1, 3, 0, 2, 1);
        tbl[12] = mk(0, K_NONE,  1, 1, 0, 1, 1, 1);
        tbl[13] = mk(0, K_NONE,  0, 1, 0, 0, 1, 1);
        tbl[14] = mk(0, K_NONE,  1, 1, 2, 1, 0, 1);
        tbl[15] = mk(0, K_NONE,  0, 1, 2, 0, 0, 1);
        // Push coincident with pop on a full queue; drain to prove [left, down]
        tbl[16] = mk(1, K_NONE,  0, 1, 3, 0, 0, 0);
        tbl[17] = mk(0, K_UP,    0, 1, 3, 0, 1, 0);
        tbl[18] = mk(0, K_LEFT,  0, 1, 3, 0, 2, 0);
        tbl[19] = mk(0, K_DOWN,  1, 1, 0, 1, 2, 0);
        tbl[20] = mk(0, K_NONE,  1, 1, 2, 1, 1, 0);
        tbl[21] = mk(0, K_NONE,  1, 1, 1, 1, 0, 0);
        tbl[22] = mk(0, K_NONE,  0, 1, 1, 0, 0, 0);
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; key_left = 0; key_right = 0; key_up = 0; key_down = 0;
        move_tick = 0; game_en = 0;
        m_dir = 3; m_turn = 0; m_rej = 0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NTBL; i++) begin
            step(tbl[i].r, tbl[i].k, tbl[i].t, tbl[i].e);
            check_all($sformatf("tbl%0d", i), tbl[i].e_dir, tbl[i].e_turn,
                      tbl[i].e_q, tbl[i].e_rej);
        end

        // Two keys at once, then Key_up held for 300 cycles
        step(1, K_NONE, 0, 1);
        step(0, K_UP | K_LEFT, 0, 1);
        check_all("multi", 3, 0, 0, 1);
        for (int c = 1; c <= 300; c++) begin
            step(0, K_UP, 0, 1);
            check("hold.q_count", int'(q_count), 1);
            check("hold.rej_cnt", int'(rej_cnt), (c < 255) ? c : 255);
        end
        step(0, K_NONE, 0, 1);
        check_all("hold_end", 3, 0, 1, 255);

        // Pause with a full queue and a coincident tick / key
        step(1, K_NONE, 0, 1);
        step(0, K_UP,   0, 1);
        step(0, K_LEFT, 0, 1);
        check_all("pre_pause", 3, 0, 2, 0);
        step(0, K_DOWN, 1, 0);
        check_all("pause", 3, 0, 0, 0);
        step(0, K_UP,   0, 1);
        check_all("resume_push", 3, 0, 1, 0);
        step(0, K_NONE, 1, 1);
        check_all("resume_pop", 0, 1, 0, 0);
        step(0, K_LEFT, 0, 1);
        step(0, K_RIGHT, 0, 1);
        check_all("pre_rst", 0, 0, 1, 1);
        // Reset mid-operation, coincident with a tick that would have popped
        step(1, K_NONE, 1, 1);
        check_all("mid_rst", 3, 0, 0, 0);
        step(0, K_NONE, 1, 1);
        check_all("post_rst", 3, 0, 0, 0);

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            logic       r, t, e;
            logic [3:0] k;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 15) != 0);
            t = ($urandom_range(0, 2) == 0);
            k = 4'b0000;
            for (int b = 0; b < 4; b++) k[b] = ($urandom_range(0, 5) == 0);
            step(r, k, t, e);
            check_all("rand", m_dir, m_turn, m_q.size(), m_rej);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/direction_ctrl_module.md
DIRECTION_CTRL_MODULE -- requirements
Module: direction_ctrl_module

Interface
REQ-001 The module SHALL have exactly one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Clk_50mhz  input  1  system clock, 50 MHz; all state updates on its rising edge.
REQ-003 Rst  input  1  synchronous reset, active-high.
REQ-004 Key_left, Key_right, Key_up, Key_down  input  1 each  debounced key-press pulses, one cycle high per press.
REQ-005 Move_tick  input  1  single-cycle game-step strobe.
REQ-006 Game_en  input  1  level; 1 = play, 0 = paused or flushed.
REQ-007 Dir  output  2  current heading, registered: 00 up, 01 down, 10 left, 11 right.
REQ-008 Turn  output  1  registered pulse, high for the single cycle in which Dir holds a newly applied value.
REQ-009 Q_count  output  2  number of pending queued directions, 0..2.
REQ-010 Rej_cnt  output  8  count of rejected key events; saturates at 255.

Function
REQ-011 The block SHALL hold a 2-entry FIFO of requested directions, with head, tail and count registers.
REQ-012 A key event is a cycle in which at least one Key_* input is high.
REQ-013 A key event with more than one Key_* input high SHALL be rejected as a whole.
REQ-014 The reference direction SHALL be the tail entry when count > 0 at the start of the cycle, otherwise Dir.
REQ-015 A single-key event SHALL be rejected if the requested direction equals the reference direction.
REQ-016 A single-key event SHALL be rejected if the requested direction is the opposite of the reference direction (up/down, left/right).
REQ-017 A single-key event SHALL be rejected if count == 2, unless a pop occurs in the same cycle.
REQ-018 Otherwise the event SHALL be pushed at the tail, and Q_count SHALL reflect it on the next cycle.
REQ-019 Each rejected event SHALL increment Rej_cnt by exactly 1, whatever the reason; Rej_cnt SHALL saturate at 255.
REQ-020 Pop: on a Move_tick cycle with count > 0 and Game_en = 1, the head SHALL load into Dir at that clock edge and Turn SHALL be 1 for the following cycle only.
REQ-021 A Move_tick with count == 0 SHALL leave Dir unchanged and SHALL keep Turn at 0.
REQ-022 When push and pop occur in the same cycle, both SHALL take effect, the count SHALL be unchanged, and the reference SHALL follow REQ-014 using pre-edge state.
REQ-023 Push and pop in the same cycle at count == 2 SHALL be accepted.
REQ-024 Push and pop in the same cycle at count == 1 SHALL leave the new entry as the sole queued entry.
REQ-025 Latency SHALL be: key pulse at cycle N, push visible at N+1; Move_tick at cycle M with non-empty queue, Dir and Turn updated at M+1.
REQ-026 While Game_en = 0: the FIFO SHALL be flushed (count forced to 0 at the next edge), Key_* and Move_tick SHALL be ignored (no push, no pop, no Rej_cnt change), and Dir SHALL be held.
REQ-027 When Game_en rises, operation SHALL resume from the held Dir with an empty queue.
REQ-028 The block SHALL not check that key inputs are single-cycle; a key held for k cycles SHALL be treated as k events.

Reset
REQ-029 When Rst = 1 at a rising edge, the next state SHALL be: Dir = 11 (right), Turn = 0, Q_count = 0, FIFO pointers = 0, Rej_cnt = 0.
REQ-030 Rst SHALL take priority over Game_en, Move_tick and all Key_* inputs.
REQ-031 A reset asserted mid-operation SHALL discard all queued entries, and no Turn pulse SHALL follow it.

Verification
REQ-032 The bench SHALL cover: release reset, Game_en = 1, Key_up pulse, then Move_tick -> Q_count goes 0 -> 1 -> 0; Dir = 00 and Turn = 1 for one cycle after the tick; Rej_cnt = 0.
REQ-033 The bench SHALL cover: Dir = 11, Key_left pulse -> rejected (opposite), Q_count stays 0, Rej_cnt = 1; then Key_right pulse -> rejected (same), Rej_cnt = 2.
REQ-034 The bench SHALL cover: Dir = 11, pulses Key_up, then Key_left, then Key_down -> first two queued (Q_count = 2), Key_down rejected (full), Rej_cnt = 1; two Move_ticks -> Dir 00 then 10, each with one Turn pulse.
REQ-035 The bench SHALL cover: queue [up, left] (Q_count = 2), Key_down coincident with Move_tick -> pop and push both occur; Dir = 00, queue [left, down], Q_count = 2, Rej_cnt unchanged.
REQ-036 The bench SHALL cover: Key_up and Key_left high in the same cycle -> no push, Rej_cnt += 1; then a Key_up pulse held 300 cycles -> 1 push plus 299 rejections (same-direction), with Rej_cnt saturating at 255.
REQ-037 The bench SHALL cover: queue holding 2 entries, drop Game_en for 1 cycle with Move_tick high -> Q_count = 0, Dir unchanged, Turn = 0; assert Rst mid-operation -> Dir = 11 and all counters 0 on the next cycle.
